// File: rtl/hypercorex_csr_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hypercorex_csr_master_pkg
// Description : Shared types for the Hypercorex CSR master: FSM state
//               encoding, latched command record and the poll compare rule.
// Revision    : 1.0 - initial release
// ============================================================================
package hypercorex_csr_master_pkg;

   // Field widths of the latched command record; the master's width
   // parameters default to these values and must match them.
   localparam int unsigned CSR_DATA_W = 32;
   localparam int unsigned CSR_ADDR_W = 32;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      RSP  = 3'd2,
      GAP  = 3'd3,
      OUT  = 3'd4
   } state_e;

   typedef struct packed {
      logic                  write;
      logic                  poll;
      logic [CSR_ADDR_W-1:0] addr;
      logic [CSR_DATA_W-1:0] data;
      logic [CSR_DATA_W-1:0] mask;
   } cmd_t;

   // Poll succeeds when the masked response equals the masked expected value.
   function automatic logic poll_match(
      input logic [CSR_DATA_W-1:0] rsp,
      input logic [CSR_DATA_W-1:0] data,
      input logic [CSR_DATA_W-1:0] mask
   );
      return ((rsp & mask) == (data & mask));
   endfunction

endpackage
`default_nettype wire

// File: rtl/hypercorex_csr_master.sv
`default_nettype none
// ============================================================================
// Module      : hypercorex_csr_master
// Description : Initiator end of the Hypercorex CSR req/rsp interface.
//               Accepts one write / read / poll-read command at a time,
//               issues CSR requests and returns read results on a
//               valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module hypercorex_csr_master
   import hypercorex_csr_master_pkg::*;
#(
   parameter int unsigned CsrDataWidth = CSR_DATA_W,
   parameter int unsigned CsrAddrWidth = CSR_ADDR_W,
   parameter int unsigned PollMax      = 256,
   parameter int unsigned PollGap      = 4,
   parameter int unsigned CntWidth     = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   // command port
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic                    cmd_write_i,
   input  logic                    cmd_poll_i,
   input  logic [CsrAddrWidth-1:0] cmd_addr_i,
   input  logic [CsrDataWidth-1:0] cmd_data_i,
   input  logic [CsrDataWidth-1:0] cmd_mask_i,
   // CSR request channel
   output logic [CsrDataWidth-1:0] csr_req_data_o,
   output logic [CsrAddrWidth-1:0] csr_req_addr_o,
   output logic                    csr_req_write_o,
   output logic                    csr_req_valid_o,
   input  logic                    csr_req_ready_i,
   // CSR response channel
   input  logic [CsrDataWidth-1:0] csr_rsp_data_i,
   input  logic                    csr_rsp_valid_i,
   output logic                    csr_rsp_ready_o,
   // read result port
   output logic [CsrDataWidth-1:0] rd_data_o,
   output logic                    rd_timeout_o,
   output logic                    rd_valid_o,
   input  logic                    rd_ready_i,
   // status
   output logic                    busy_o,
   output logic [CntWidth-1:0]     txn_count_o
);

   // Attempt counter must hold PollMax; gap counter keeps one bit even when
   // PollGap is zero so the declaration stays legal.
   localparam int unsigned PCW = $clog2(PollMax + 1);
   localparam int unsigned GCW = (PollGap > 0) ? $clog2(PollGap + 1) : 1;

   localparam logic [PCW-1:0] c_poll_last = PCW'(PollMax);
   localparam logic [GCW-1:0] c_gap_load  = GCW'(PollGap);
   localparam logic [GCW-1:0] c_gap_one   = GCW'(1);

   state_e                  r_state;
   state_e                  w_state_nxt;
   cmd_t                    r_cmd;
   logic [PCW-1:0]          r_poll_cnt;
   logic [GCW-1:0]          r_gap_cnt;
   logic [CsrDataWidth-1:0] r_rd_data;
   logic                    r_rd_timeout;
   logic [CntWidth-1:0]     r_txn_cnt;

   logic                    w_match;
   logic [PCW-1:0]          w_poll_cnt_inc;
   logic                    w_poll_last;

   assign w_match        = poll_match(csr_rsp_data_i, r_cmd.data, r_cmd.mask);
   assign w_poll_cnt_inc = r_poll_cnt + 1'b1;
   assign w_poll_last    = (w_poll_cnt_inc == c_poll_last);

   // Request fields come straight from the latched command so they hold
   // steady for as long as the responder stalls.
   assign csr_req_data_o  = r_cmd.data;
   assign csr_req_addr_o  = r_cmd.addr;
   assign csr_req_write_o = r_cmd.write;
   assign rd_data_o       = r_rd_data;
   assign rd_timeout_o    = r_rd_timeout;
   assign busy_o          = (r_state != IDLE);
   assign txn_count_o     = r_txn_cnt;

   // State register; async reset abandons any transaction in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      w_state_nxt     = r_state;
      cmd_ready_o     = 1'b0;
      csr_req_valid_o = 1'b0;
      csr_rsp_ready_o = 1'b0;
      rd_valid_o      = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) w_state_nxt = REQ;
         end
         REQ: begin
            csr_req_valid_o = 1'b1;
            if (csr_req_ready_i) w_state_nxt = RSP;
         end
         RSP: begin
            csr_rsp_ready_o = 1'b1;
            if (csr_rsp_valid_i) begin
               if (r_cmd.write) begin
                  w_state_nxt = IDLE;
               end else if (!r_cmd.poll || w_match || w_poll_last) begin
                  w_state_nxt = OUT;
               end else if (PollGap == 0) begin
                  w_state_nxt = REQ;
               end else begin
                  w_state_nxt = GAP;
               end
            end
         end
         GAP: begin
            if (r_gap_cnt == c_gap_one) w_state_nxt = REQ;
         end
         OUT: begin
            rd_valid_o = 1'b1;
            if (rd_ready_i) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Command latch, poll/gap counters, result capture and transaction count.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cmd        <= '0;
         r_poll_cnt   <= '0;
         r_gap_cnt    <= '0;
         r_rd_data    <= '0;
         r_rd_timeout <= 1'b0;
         r_txn_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid_i) begin
                  r_cmd.write <= cmd_write_i;
                  r_cmd.poll  <= cmd_poll_i & ~cmd_write_i;
                  r_cmd.addr  <= cmd_addr_i;
                  r_cmd.data  <= cmd_data_i;
                  r_cmd.mask  <= cmd_mask_i;
                  r_poll_cnt  <= '0;
               end
            end
            RSP: begin
               if (csr_rsp_valid_i) begin
                  r_txn_cnt  <= r_txn_cnt + 1'b1;
                  r_poll_cnt <= w_poll_cnt_inc;
                  r_gap_cnt  <= c_gap_load;
                  // Write responses carry nothing useful; keep the last result.
                  if (!r_cmd.write) begin
                     r_rd_data    <= csr_rsp_data_i;
                     r_rd_timeout <= r_cmd.poll & ~w_match & w_poll_last;
                  end
               end
            end
            GAP: begin
               r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hypercorex_csr_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hypercorex_csr_master
// Description : Directed self-checking bench for hypercorex_csr_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hypercorex_csr_master;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int PM = 4;
   localparam int PG = 2;
   localparam int CW = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          cmd_valid_i, cmd_ready_o, cmd_write_i, cmd_poll_i;
   logic [AW-1:0] cmd_addr_i;
   logic [DW-1:0] cmd_data_i, cmd_mask_i;
   logic [DW-1:0] csr_req_data_o;
   logic [AW-1:0] csr_req_addr_o;
   logic          csr_req_write_o, csr_req_valid_o, csr_req_ready_i;
   logic [DW-1:0] csr_rsp_data_i;
   logic          csr_rsp_valid_i, csr_rsp_ready_o;
   logic [DW-1:0] rd_data_o;
   logic          rd_timeout_o, rd_valid_o, rd_ready_i, busy_o;
   logic [CW-1:0] txn_count_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int hs_cyc[$];

   hypercorex_csr_master #(
      .CsrDataWidth (DW),
      .CsrAddrWidth (AW),
      .PollMax      (PM),
      .PollGap      (PG),
      .CntWidth     (CW)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .cmd_valid_i     (cmd_valid_i),
      .cmd_ready_o     (cmd_ready_o),
      .cmd_write_i     (cmd_write_i),
      .cmd_poll_i      (cmd_poll_i),
      .cmd_addr_i      (cmd_addr_i),
      .cmd_data_i      (cmd_data_i),
      .cmd_mask_i      (cmd_mask_i),
      .csr_req_data_o  (csr_req_data_o),
      .csr_req_addr_o  (csr_req_addr_o),
      .csr_req_write_o (csr_req_write_o),
      .csr_req_valid_o (csr_req_valid_o),
      .csr_req_ready_i (csr_req_ready_i),
      .csr_rsp_data_i  (csr_rsp_data_i),
      .csr_rsp_valid_i (csr_rsp_valid_i),
      .csr_rsp_ready_o (csr_rsp_ready_o),
      .rd_data_o       (rd_data_o),
      .rd_timeout_o    (rd_timeout_o),
      .rd_valid_o      (rd_valid_o),
      .rd_ready_i      (rd_ready_i),
      .busy_o          (busy_o),
      .txn_count_o     (txn_count_o)
   );

   always #5 clk_i = ~clk_i;

   // Record the cycle index of every request handshake.
   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (rst_ni && csr_req_valid_o && csr_req_ready_i) hs_cyc.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present a command at a negedge and hold it until accepted; returns at
   // the negedge after the handshake edge.
   task automatic send_cmd(input logic wr, input logic pl, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] m);
      int k;
      @(negedge clk_i);
      cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_poll_i = pl;
      cmd_addr_i  = a;    cmd_data_i  = d;  cmd_mask_i = m;
      k = 0;
      while (!cmd_ready_o && k < 50) begin @(negedge clk_i); k++; end
      chk("cmd_accept_in_time", 64'(k < 50), 64'd1);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
   endtask

   // Act as responder for one transaction: stall ready for dly cycles while
   // checking the request holds, then accept and answer with rdat.
   task automatic respond(input int dly, input logic [DW-1:0] rdat, input logic wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      int k;
      int stable;
      k = 0;
      stable = 0;
      while (!csr_req_valid_o && k < 50) begin @(negedge clk_i); k++; end
      chk("req_valid_in_time", 64'(k < 50), 64'd1);
      for (int i = 0; i <= dly; i++) begin
         if (csr_req_valid_o && csr_req_addr_o === a && csr_req_data_o === d &&
             csr_req_write_o === wr) stable++;
         if (i < dly) @(negedge clk_i);
      end
      chk("req_stable_cycles", 64'(stable), 64'(dly + 1));
      csr_req_ready_i = 1'b1;
      @(negedge clk_i);
      csr_req_ready_i = 1'b0;
      chk("rsp_ready_in_rsp", 64'(csr_rsp_ready_o), 64'd1);
      csr_rsp_valid_i = 1'b1;
      csr_rsp_data_i  = rdat;
      @(negedge clk_i);
      csr_rsp_valid_i = 1'b0;
   endtask

   // Consume a read result after holding rd_ready_i low for dly cycles.
   task automatic drain(input int dly, input logic [DW-1:0] exp_d, input logic exp_to);
      int k;
      int held;
      k = 0;
      held = 0;
      while (!rd_valid_o && k < 50) begin @(negedge clk_i); k++; end
      chk("rd_valid_in_time", 64'(k < 50), 64'd1);
      chk("rd_data", 64'(rd_data_o), 64'(exp_d));
      chk("rd_timeout", 64'(rd_timeout_o), 64'(exp_to));
      for (int i = 0; i < dly; i++) begin
         @(negedge clk_i);
         if (rd_valid_o && !cmd_ready_o && rd_data_o === exp_d) held++;
      end
      chk("rd_held_cycles", 64'(held), 64'(dly));
      rd_ready_i = 1'b1;
      @(negedge clk_i);
      rd_ready_i = 1'b0;
      chk("rd_valid_after_drain", 64'(rd_valid_o), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      rst_ni = 1'b0;
      cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_poll_i = 1'b0;
      cmd_addr_i = '0; cmd_data_i = '0; cmd_mask_i = '0;
      csr_req_ready_i = 1'b0; csr_rsp_valid_i = 1'b0; csr_rsp_data_i = '0;
      rd_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);

      // Reset state
      chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("rst_req_valid", 64'(csr_req_valid_o), 64'd0);
      chk("rst_req_addr", 64'(csr_req_addr_o), 64'd0);
      chk("rst_req_data", 64'(csr_req_data_o), 64'd0);
      chk("rst_rsp_ready", 64'(csr_rsp_ready_o), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_txn", 64'(txn_count_o), 64'd0);
      rst_ni = 1'b1;

      // Write 0xA5 to 0x04, responder ready immediately
      n0 = hs_cyc.size();
      send_cmd(1'b1, 1'b0, 32'h04, 32'h0000_00A5, 32'h0);
      chk("wr_req_valid_at_1", 64'(csr_req_valid_o), 64'd1);
      respond(0, 32'h0, 1'b1, 32'h04, 32'h0000_00A5);
      chk("wr_no_rd_valid", 64'(rd_valid_o), 64'd0);
      chk("wr_idle", 64'(busy_o), 64'd0);
      chk("wr_req_count", 64'(hs_cyc.size() - n0), 64'd1);
      chk("wr_txn", 64'(txn_count_o), 64'd1);

      // Read 0x08 with a 3-cycle responder stall
      send_cmd(1'b0, 1'b0, 32'h08, 32'h0, 32'h0);
      respond(3, 32'hDEAD_BEEF, 1'b0, 32'h08, 32'h0);
      drain(0, 32'hDEAD_BEEF, 1'b0);
      chk("rd_txn", 64'(txn_count_o), 64'd2);

      // Poll 0x0C for bit0 clear: responses 1,1,0
      n0 = hs_cyc.size();
      send_cmd(1'b0, 1'b1, 32'h0C, 32'h0, 32'h1);
      respond(0, 32'h1, 1'b0, 32'h0C, 32'h0);
      respond(0, 32'h1, 1'b0, 32'h0C, 32'h0);
      respond(0, 32'h0, 1'b0, 32'h0C, 32'h0);
      drain(0, 32'h0, 1'b0);
      chk("poll_req_count", 64'(hs_cyc.size() - n0), 64'd3);
      chk("poll_spacing_1", 64'((hs_cyc[n0 + 1] - hs_cyc[n0]) >= PG + 2), 64'd1);
      chk("poll_spacing_2", 64'((hs_cyc[n0 + 2] - hs_cyc[n0 + 1]) >= PG + 2), 64'd1);
      chk("poll_txn", 64'(txn_count_o), 64'd5);

      // Poll that never matches: exactly PollMax attempts then timeout
      n0 = hs_cyc.size();
      send_cmd(1'b0, 1'b1, 32'h10, 32'h0, 32'h1);
      for (int i = 0; i < PM; i++) respond(0, 32'h1, 1'b0, 32'h10, 32'h0);
      chk("to_no_extra_req", 64'(csr_req_valid_o), 64'd0);
      drain(0, 32'h1, 1'b1);
      chk("to_req_count", 64'(hs_cyc.size() - n0), 64'(PM));
      chk("to_txn", 64'(txn_count_o), 64'd9);

      // Mask 0 poll matches on the first attempt
      n0 = hs_cyc.size();
      send_cmd(1'b0, 1'b1, 32'h14, 32'hFF, 32'h0);
      respond(0, 32'h77, 1'b0, 32'h14, 32'hFF);
      drain(0, 32'h77, 1'b0);
      chk("mask0_req_count", 64'(hs_cyc.size() - n0), 64'd1);

      // Result back-pressure: new command waits until the result drains
      send_cmd(1'b0, 1'b0, 32'h20, 32'h0, 32'h0);
      respond(0, 32'h1234_5678, 1'b0, 32'h20, 32'h0);
      cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_poll_i = 1'b0;
      cmd_addr_i = 32'h24; cmd_data_i = 32'h5A; cmd_mask_i = 32'h0;
      drain(5, 32'h1234_5678, 1'b0);
      chk("bp_cmd_ready_after_drain", 64'(cmd_ready_o), 64'd1);
      chk("bp_txn", 64'(txn_count_o), 64'd11);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      chk("bp_cmd_taken", 64'(csr_req_valid_o), 64'd1);
      respond(0, 32'h0, 1'b1, 32'h24, 32'h5A);
      chk("bp_txn_after_wr", 64'(txn_count_o), 64'd12);

      // Transaction counter wraps at 2^CntWidth
      for (int i = 0; i < 3; i++) begin
         send_cmd(1'b1, 1'b0, 32'h30, 32'(i), 32'h0);
         respond(0, 32'h0, 1'b1, 32'h30, 32'(i));
      end
      chk("txn_all_ones", 64'(txn_count_o), 64'd15);
      send_cmd(1'b1, 1'b0, 32'h30, 32'h3, 32'h0);
      respond(0, 32'h0, 1'b1, 32'h30, 32'h3);
      chk("txn_wrap", 64'(txn_count_o), 64'd0);
      send_cmd(1'b1, 1'b0, 32'h34, 32'h9, 32'h0);
      respond(0, 32'h0, 1'b1, 32'h34, 32'h9);
      chk("txn_after_wrap", 64'(txn_count_o), 64'd1);

      // Reset while waiting for a response
      send_cmd(1'b0, 1'b0, 32'h40, 32'h0, 32'h0);
      csr_req_ready_i = 1'b1;
      @(negedge clk_i);
      csr_req_ready_i = 1'b0;
      chk("mid_in_rsp", 64'(csr_rsp_ready_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("mid_rst_rsp_ready", 64'(csr_rsp_ready_o), 64'd0);
      @(negedge clk_i);
      chk("mid_rst_busy", 64'(busy_o), 64'd0);
      chk("mid_rst_req_addr", 64'(csr_req_addr_o), 64'd0);
      chk("mid_rst_txn", 64'(txn_count_o), 64'd0);
      chk("mid_rst_rd_data", 64'(rd_data_o), 64'd0);
      rst_ni = 1'b1;
      csr_rsp_valid_i = 1'b1;
      csr_rsp_data_i  = 32'hCAFE_F00D;
      @(negedge clk_i);
      csr_rsp_valid_i = 1'b0;
      @(negedge clk_i);
      chk("late_rsp_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("late_rsp_txn", 64'(txn_count_o), 64'd0);
      chk("late_rsp_rd_valid", 64'(rd_valid_o), 64'd0);
      chk("late_rsp_rd_data", 64'(rd_data_o), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
